// File: rtl/pio_in_edge_irq.sv
// -----------------------------------------------------------------------------
// pio_in_edge_irq
//   Input PIO for switches/buttons. WIDTH asynchronous pins are synchronised,
//   optionally debounced per bit, and edge-detected into a sticky
//   edge-capture register. A maskable level interrupt is raised while any
//   unmasked captured edge is pending. Register access is through an
//   Avalon-MM slave with a fixed one-cycle read latency and no wait states.
//
// Ports
//   clk         system clock (single domain)
//   reset_n     asynchronous active-low reset
//   address     Avalon word address (0 data, 2 irqmask, 3 edgecapture)
//   chipselect  Avalon select, qualifies writes
//   write_n     Avalon write strobe, active low
//   writedata   Avalon write data
//   readdata    registered Avalon read data
//   in_port     asynchronous external pins
//   irq         level interrupt, active high
// -----------------------------------------------------------------------------
module pio_in_edge_irq #(
   parameter int WIDTH           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   // Edges are ignored until the pipeline (sync + filter + prev) has been
   // filled with real pin values, so pins held high through reset never look
   // like a 0->1 transition.
   localparam int              ARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
   localparam int              ARM_W      = $clog2(ARM_CYCLES + 1);
   localparam logic [ARM_W-1:0] ARM_DONE  = ARM_W'(ARM_CYCLES);
   localparam logic [ARM_W-1:0] ARM_ONE   = ARM_W'(1);
   localparam logic [1:0]      EDGE_SEL   = 2'(EDGE_TYPE);

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] sync_s;
   logic [WIDTH-1:0] filt_s;
   logic [WIDTH-1:0] prev_r;
   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] edge_det_s;
   logic [ARM_W-1:0] arm_cnt_r;
   logic             armed_s;
   logic [WIDTH-1:0] irqmask_r;
   logic [WIDTH-1:0] edgecapture_r;
   logic             wr_s;
   logic             wr_mask_s;
   logic             wr_clr_s;
   logic [WIDTH-1:0] clr_s;
   logic [31:0]      rd_next_s;
   logic             wdata_unused_s;

   // Bits of writedata above WIDTH-1 have no destination.
   assign wdata_unused_s = ^writedata;

   // Synchroniser chain: stage 0 samples the asynchronous pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= '0;
         end
      end else begin
         sync_r[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   assign sync_s = sync_r[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES > 0) begin : g_debounce
         localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
         localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);

         logic [DB_W-1:0]  cnt_r [WIDTH];
         logic [WIDTH-1:0] filt_r;

         // Per-bit filter: filt follows s only after DEBOUNCE_CYCLES
         // consecutive cycles of disagreement; any agreement restarts the count.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               filt_r <= '0;
               for (int i = 0; i < WIDTH; i++) begin
                  cnt_r[i] <= '0;
               end
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (sync_s[i] == filt_r[i]) begin
                     cnt_r[i] <= '0;
                  end else if (cnt_r[i] == DB_LAST) begin
                     cnt_r[i]  <= '0;
                     filt_r[i] <= sync_s[i];
                  end else begin
                     cnt_r[i] <= cnt_r[i] + DB_ONE;
                  end
               end
            end
         end

         assign filt_s = filt_r;
      end else begin : g_no_debounce
         assign filt_s = sync_s;
      end
   endgenerate

   // Previous filtered value for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_r <= '0;
      end else begin
         prev_r <= filt_s;
      end
   end

   assign rise_s = filt_s & ~prev_r;
   assign fall_s = ~filt_s & prev_r;

   // Edge polarity selection.
   always_comb begin
      edge_s = '0;
      case (EDGE_SEL)
         2'd0:    edge_s = rise_s;
         2'd1:    edge_s = fall_s;
         2'd2:    edge_s = rise_s | fall_s;
         default: edge_s = rise_s;
      endcase
   end

   // Arm counter: counts up after reset release and saturates once armed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arm_cnt_r <= '0;
      end else if (!armed_s) begin
         arm_cnt_r <= arm_cnt_r + ARM_ONE;
      end else begin
         arm_cnt_r <= arm_cnt_r;
      end
   end

   assign armed_s    = (arm_cnt_r == ARM_DONE);
   assign edge_det_s = edge_s & {WIDTH{armed_s}};

   // Avalon write decode and write-1-to-clear vector.
   always_comb begin
      wr_s      = chipselect & ~write_n;
      wr_mask_s = wr_s && (address == 3'd2);
      wr_clr_s  = wr_s && (address == 3'd3);
      if (wr_clr_s) begin
         clr_s = writedata[WIDTH-1:0];
      end else begin
         clr_s = '0;
      end
   end

   // Interrupt mask register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_r <= '0;
      end else if (wr_mask_s) begin
         irqmask_r <= writedata[WIDTH-1:0];
      end else begin
         irqmask_r <= irqmask_r;
      end
   end

   // Sticky edge capture; a new edge wins over a coincident clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecapture_r <= '0;
      end else begin
         edgecapture_r <= edge_det_s | (edgecapture_r & ~clr_s);
      end
   end

   // Read mux; unmapped addresses and unused upper bits return zero.
   always_comb begin
      rd_next_s = '0;
      case (address)
         3'd0:    rd_next_s[WIDTH-1:0] = filt_s;
         3'd2:    rd_next_s[WIDTH-1:0] = irqmask_r;
         3'd3:    rd_next_s[WIDTH-1:0] = edgecapture_r;
         default: rd_next_s = '0;
      endcase
   end

   // Registered read data (one-cycle latency, independent of chipselect).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_next_s;
      end
   end

   // Registered level interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |(edgecapture_r & irqmask_r);
      end
   end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
module tb_pio_in_edge_irq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [2:0]  cs = 3'b000;
   logic [9:0]  in0 = 10'd0;
   logic [9:0]  in1 = 10'd0;
   logic [31:0] in2 = 32'd0;
   logic [31:0] rd0, rd1, rd2;
   logic        irq0, irq1, irq2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // u0: defaults (rising edges, no debounce)
   pio_in_edge_irq #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
      .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));

   // u1: 3-stage sync, 8-cycle debounce, falling edges
   pio_in_edge_irq #(.WIDTH(10), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(1)) u1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
      .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));

   // u2: 32 bits, any edge
   pio_in_edge_irq #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
      .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int dut, input logic [2:0] a, input logic [31:0] d);
      cs = 3'b000;
      cs[dut] = 1'b1;
      address = a;
      writedata = d;
      write_n = 1'b0;
      tick();
      write_n = 1'b1;
      cs = 3'b000;
   endtask

   // reference model state for the randomized phase
   logic [9:0] hist_q [$];
   logic [9:0] ec_m, ec_old, mask_m, pin, rise_m, clr_m;
   logic [31:0] wd;
   logic        do_wr;
   int          nz;

   initial begin
      // ---------------- reset with pins held high ----------------
      in0 = 10'h3FF;
      tick(3);
      chk("rst_readdata", rd0, 32'h0);
      chk("rst_irq", {31'd0, irq0}, 32'h0);
      reset_n = 1'b1;
      tick(10);
      address = 3'd3;
      tick();
      chk("arm_no_capture", rd0, 32'h0);
      chk("arm_irq", {31'd0, irq0}, 32'h0);
      address = 3'd0;
      tick();
      chk("data_default", rd0, 32'h3FF);
      address = 3'd2;
      tick();
      chk("mask_default", rd0, 32'h0);

      // ---------------- basic rising edge + irq latency ----------------
      in0 = 10'h000;
      tick(5);
      wr(0, 3'd2, 32'hFFFF_FC04);           // bits above WIDTH ignored
      tick();
      chk("mask_readback", rd0, 32'h004);
      address = 3'd3;
      tick();
      in0 = 10'h004;
      tick(3);
      chk("irq_not_yet", {31'd0, irq0}, 32'h0);
      tick();
      chk("irq_latency", {31'd0, irq0}, 32'h1);
      chk("ec_bit2", rd0, 32'h004);
      wr(0, 3'd3, 32'h0000_0004);
      chk("read_prewrite", rd0, 32'h004);
      tick();
      chk("ec_cleared", rd0, 32'h0);
      chk("irq_cleared", {31'd0, irq0}, 32'h0);

      // ---------------- masked edge, then unmask ----------------
      wr(0, 3'd2, 32'h0);
      address = 3'd3;
      in0 = 10'h024;
      tick(6);
      chk("masked_ec", rd0, 32'h020);
      chk("masked_irq", {31'd0, irq0}, 32'h0);
      wr(0, 3'd2, 32'h0000_0020);
      chk("unmask_irq_same", {31'd0, irq0}, 32'h0);
      tick();
      chk("unmask_irq", {31'd0, irq0}, 32'h1);
      wr(0, 3'd3, 32'h0000_03FF);
      wr(0, 3'd2, 32'h0);
      address = 3'd3;

      // ---------------- set/clear collision on bit 1 ----------------
      in0 = 10'h026;
      tick(2);
      wr(0, 3'd3, 32'h0000_0002);           // active on the edge the rise is captured
      tick();
      chk("collision", rd0, 32'h002);

      // ---------------- unmapped address ----------------
      wr(0, 3'd1, 32'hFFFF_FFFF);
      address = 3'd1;
      tick();
      chk("addr1_read", rd0, 32'h0);
      address = 3'd2;
      tick();
      chk("addr1_write_ignored", rd0, 32'h0);

      // ---------------- randomized phase on u0 ----------------
      in0 = 10'h000;
      tick(4);
      wr(0, 3'd3, 32'h0000_03FF);
      wr(0, 3'd2, 32'h0000_03FF);
      address = 3'd3;
      tick(4);
      mask_m = 10'h3FF;
      ec_m = 10'h000;
      pin = 10'h000;
      hist_q = {10'h000, 10'h000, 10'h000};
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 2) == 0) pin = 10'($urandom);
         do_wr = ($urandom_range(0, 3) == 0);
         wd = $urandom;
         in0 = pin;
         if (do_wr) begin
            cs = 3'b001;
            write_n = 1'b0;
            writedata = wd;
         end else begin
            cs = 3'b000;
            write_n = 1'b1;
         end
         @(posedge clk);
         // a pin change seen at this edge reaches edgecapture two edges later
         hist_q.push_back(pin);
         rise_m = hist_q[$-2] & ~hist_q[$-3];
         clr_m = do_wr ? wd[9:0] : 10'h000;
         ec_old = ec_m;
         ec_m = rise_m | (ec_old & ~clr_m);
         if (hist_q.size() > 8) void'(hist_q.pop_front());
         #1;
         chk("rnd_ec", rd0, {22'd0, ec_old});
         chk("rnd_irq", {31'd0, irq0}, {31'd0, |(ec_old & mask_m)});
      end
      cs = 3'b000;
      write_n = 1'b1;

      // ---------------- debounce on u1 (SYNC 3, 8 cycles, falling) -------
      address = 3'd0;
      in1 = 10'h001;
      tick(5);
      in1 = 10'h000;
      nz = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (rd1 != 32'h0) nz++;
      end
      chk("db_glitch_data", nz, 32'h0);
      address = 3'd3;
      tick();
      chk("db_glitch_ec", rd1, 32'h0);
      address = 3'd0;
      tick();
      in1 = 10'h001;
      tick(11);
      chk("db_data_early", rd1, 32'h0);
      tick();
      chk("db_data", rd1, 32'h1);
      address = 3'd3;
      tick(2);
      chk("db_rise_ignored", rd1, 32'h0);
      tick(6);
      in1 = 10'h000;
      tick(16);
      chk("db_fall_capture", rd1, 32'h1);

      // ---------------- any-edge, 32-bit on u2 ----------------
      in2 = 32'h8000_0000;
      tick(5);
      chk("any_rise", rd2, 32'h8000_0000);
      address = 3'd0;
      tick();
      chk("any_data", rd2, 32'h8000_0000);
      wr(2, 3'd3, 32'h8000_0000);
      tick();
      chk("any_clr", rd2, 32'h0);
      in2 = 32'h0;
      tick(5);
      chk("any_fall", rd2, 32'h8000_0000);
      address = 3'd6;
      tick();
      chk("addr6", rd2, 32'h0);
      wr(2, 3'd2, 32'hFFFF_FFFF);
      tick();
      chk("any_irq", {31'd0, irq2}, 32'h1);

      // ---------------- asynchronous reset mid-operation ----------------
      reset_n = 1'b0;
      #1;
      chk("midrst_irq", {31'd0, irq2}, 32'h0);
      chk("midrst_readdata", rd2, 32'h0);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
